// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts an N-bit word over a valid/ready
// handshake and emits it one bit per clock with valid and last-bit strobes.
module piso_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_shift;
  logic           r_sout;
  logic           r_soutValid;
  logic           r_soutLast;

  state_t         w_stateNext;
  logic [CW-1:0]  w_countNext;
  logic [N-1:0]   w_shiftNext;
  logic           w_soutNext;
  logic           w_validNext;
  logic           w_lastNext;
  logic           w_atLast;
  logic           w_xfer;
  logic           w_loadFirst;
  logic [N-1:0]   w_loadRest;
  logic           w_shiftBit;
  logic [N-1:0]   w_shiftRest;

  assign w_atLast   = (r_count == LAST_CNT);
  assign load_ready = rst_n && ((r_state == IDLE) || w_atLast);
  assign w_xfer     = load_valid && load_ready;

  // The shift register holds the bits still to be sent, next bit at the exit end
  assign w_loadFirst = MSB_FIRST ? load_data[N-1] : load_data[0];
  assign w_loadRest  = MSB_FIRST ? {load_data[N-2:0], 1'b0} : {1'b0, load_data[N-1:1]};
  assign w_shiftBit  = MSB_FIRST ? r_shift[N-1] : r_shift[0];
  assign w_shiftRest = MSB_FIRST ? {r_shift[N-2:0], 1'b0} : {1'b0, r_shift[N-1:1]};

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_shiftNext = r_shift;
    w_soutNext  = 1'b0;
    w_validNext = 1'b0;
    w_lastNext  = 1'b0;
    if (w_xfer) begin
      w_stateNext = SHIFT;
      w_countNext = '0;
      w_shiftNext = w_loadRest;
      w_soutNext  = w_loadFirst;
      w_validNext = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext = IDLE;
        end
        SHIFT: begin
          if (w_atLast) begin
            w_stateNext = IDLE;
            w_countNext = '0;
            w_shiftNext = '0;
          end else begin
            w_countNext = r_count + 1'b1;
            w_shiftNext = w_shiftRest;
            w_soutNext  = w_shiftBit;
            w_validNext = 1'b1;
            w_lastNext  = (w_countNext == LAST_CNT);
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_countNext = '0;
          w_shiftNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_sout      <= 1'b0;
      r_soutValid <= 1'b0;
      r_soutLast  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_shift     <= w_shiftNext;
      r_sout      <= w_soutNext;
      r_soutValid <= w_validNext;
      r_soutLast  <= w_lastNext;
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_soutValid;
  assign sout_last  = r_soutLast;
  assign busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// driven by a linear sequence of steps with hand-computed expectations.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       loadValid;
  logic [3:0] loadData;
  logic       loadReady;
  logic       sout;
  logic       soutValid;
  logic       soutLast;
  logic       busy;

  logic       loadValidL;
  logic [3:0] loadDataL;
  logic       loadReadyL;
  logic       soutL;
  logic       soutValidL;
  logic       soutLastL;
  logic       busyL;

  int vectors;
  int miscompares;

  piso_serializer #(.N(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (loadValid),
    .load_data  (loadData),
    .load_ready (loadReady),
    .sout       (sout),
    .sout_valid (soutValid),
    .sout_last  (soutLast),
    .busy       (busy)
  );

  piso_serializer #(.N(4), .MSB_FIRST(1'b0)) dutL (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (loadValidL),
    .load_data  (loadDataL),
    .load_ready (loadReadyL),
    .sout       (soutL),
    .sout_valid (soutValidL),
    .sout_last  (soutLastL),
    .busy       (busyL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic expectBit(input string tag, input logic expSout, input logic expLast);
    checkOutput({tag, ".sout"}, {7'd0, sout}, {7'd0, expSout});
    checkOutput({tag, ".valid"}, {7'd0, soutValid}, 8'd1);
    checkOutput({tag, ".last"}, {7'd0, soutLast}, {7'd0, expLast});
    checkOutput({tag, ".busy"}, {7'd0, busy}, 8'd1);
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, ".sout"}, {7'd0, sout}, 8'd0);
    checkOutput({tag, ".valid"}, {7'd0, soutValid}, 8'd0);
    checkOutput({tag, ".last"}, {7'd0, soutLast}, 8'd0);
    checkOutput({tag, ".busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    logic [7:0] seq;
    logic [3:0] word;
    int         validCount;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    loadValid   = 1'b1;
    loadData    = 4'hF;
    loadValidL  = 1'b0;
    loadDataL   = 4'h0;

    // Reset, with load_valid asserted: nothing may be accepted
    applyStimulus();
    applyStimulus();
    checkOutput("rst.ready", {7'd0, loadReady}, 8'd0);
    expectIdle("rst");
    loadValid = 1'b0;
    loadData  = 4'hx;
    rst_n     = 1'b1;
    #1;
    checkOutput("post_rst.ready", {7'd0, loadReady}, 8'd1);
    applyStimulus();
    expectIdle("post_rst");

    // Test 1: 4'b1011 MSB first
    loadValid = 1'b1;
    loadData  = 4'b1011;
    applyStimulus();
    loadValid = 1'b0;
    loadData  = 4'hx;
    expectBit("t1.b0", 1'b1, 1'b0);
    checkOutput("t1.b0.ready", {7'd0, loadReady}, 8'd0);
    applyStimulus();
    expectBit("t1.b1", 1'b0, 1'b0);
    applyStimulus();
    expectBit("t1.b2", 1'b1, 1'b0);
    applyStimulus();
    expectBit("t1.b3", 1'b1, 1'b1);
    checkOutput("t1.b3.ready", {7'd0, loadReady}, 8'd1);
    applyStimulus();
    expectIdle("t1.idle");

    // Test 2: back-to-back 4'hA then 4'h5
    seq       = 8'b1010_0101;
    loadValid = 1'b1;
    loadData  = 4'hA;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      if (i == 0 || i == 4) loadValid = 1'b0;
      if (i == 3) begin
        loadValid = 1'b1;
        loadData  = 4'h5;
      end
      expectBit($sformatf("t2.b%0d", i), seq[7-i], (i == 3) || (i == 7));
    end
    applyStimulus();
    expectIdle("t2.idle");

    // Test 3: load_valid held high while busy
    loadValid = 1'b1;
    loadData  = 4'h6;
    applyStimulus();
    loadData = 4'hF;
    expectBit("t3.b0", 1'b0, 1'b0);
    checkOutput("t3.b0.ready", {7'd0, loadReady}, 8'd0);
    applyStimulus();
    expectBit("t3.b1", 1'b1, 1'b0);
    checkOutput("t3.b1.ready", {7'd0, loadReady}, 8'd0);
    applyStimulus();
    expectBit("t3.b2", 1'b1, 1'b0);
    checkOutput("t3.b2.ready", {7'd0, loadReady}, 8'd0);
    applyStimulus();
    expectBit("t3.b3", 1'b0, 1'b1);
    checkOutput("t3.b3.ready", {7'd0, loadReady}, 8'd1);
    applyStimulus();
    loadValid = 1'b0;
    expectBit("t3.f0", 1'b1, 1'b0);
    applyStimulus();
    expectBit("t3.f1", 1'b1, 1'b0);
    applyStimulus();
    expectBit("t3.f2", 1'b1, 1'b0);
    applyStimulus();
    expectBit("t3.f3", 1'b1, 1'b1);
    applyStimulus();
    expectIdle("t3.idle");

    // Test 4: LSB-first instance, 4'b0001 -> 1,0,0,0
    loadValidL = 1'b1;
    loadDataL  = 4'b0001;
    seq        = 8'b0000_0001;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      loadValidL = 1'b0;
      checkOutput($sformatf("t4.b%0d.sout", i), {7'd0, soutL}, {7'd0, seq[i]});
      checkOutput($sformatf("t4.b%0d.valid", i), {7'd0, soutValidL}, 8'd1);
      checkOutput($sformatf("t4.b%0d.last", i), {7'd0, soutLastL}, {7'd0, i == 3});
    end
    applyStimulus();
    checkOutput("t4.idle.valid", {7'd0, soutValidL}, 8'd0);
    checkOutput("t4.idle.busy", {7'd0, busyL}, 8'd0);

    // Test 5: reset after the second bit of 4'b1100
    loadValid = 1'b1;
    loadData  = 4'b1100;
    applyStimulus();
    loadValid = 1'b0;
    expectBit("t5.b0", 1'b1, 1'b0);
    applyStimulus();
    expectBit("t5.b1", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expectIdle("t5.rst");
    checkOutput("t5.rst.ready", {7'd0, loadReady}, 8'd0);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      expectIdle($sformatf("t5.after%0d", i));
    end

    // Test 6: every 4-bit word, reconstructed from the serial stream
    validCount = 0;
    for (int d = 0; d < 16; d++) begin
      loadValid = 1'b1;
      loadData  = 4'(d);
      word      = 4'h0;
      for (int i = 0; i < 5; i++) begin
        applyStimulus();
        loadValid = 1'b0;
        loadData  = 4'hx;
        if (soutValid === 1'b1) begin
          validCount++;
          word = {word[2:0], sout};
        end
      end
      checkOutput($sformatf("t6.word%0d", d), {4'd0, word}, 8'(d));
    end
    checkOutput("t6.validCount", 8'(validCount), 8'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
